// File: rtl/regfile_scoreboard_if.sv
// Register file bus: decode read/alloc, writeback write, flush, and scoreboard status.
// The master side (pipeline) drives addresses, strobes and data; the slave side (register
// file) returns read data, busy flags and the write counter.
interface regfile_scoreboard_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                flush;
    logic [NREGS-1:0]    busy_vec;
    logic [15:0]         wr_count;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        input  rd_data, rd_busy, busy_vec, wr_count
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        output rd_data, rd_busy, busy_vec, wr_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with one clocked write port, NRD combinational read ports,
// optional write-to-read bypass, hardwired zero register, a per-register busy scoreboard
// for hazard detection and a saturating count of committed writes.
module regfile_scoreboard #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1
) (
    input logic                clk,
    input logic                rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             wr_hit;
    logic             alloc_hit;

    // Writes and allocs targeting register 0 are dropped entirely.
    assign wr_hit    = bus.wr_en && (bus.wr_addr != '0);
    assign alloc_hit = bus.alloc_en && (bus.alloc_addr != '0);

    // Storage: register 0 is only ever reset, so it reads zero forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_hit) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Scoreboard next state: flush beats alloc, alloc beats a same-cycle write clear.
    always_comb begin
        busy_d = busy_q;
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            if (wr_hit) begin
                busy_d[bus.wr_addr] = 1'b0;
            end
            if (alloc_hit) begin
                busy_d[bus.alloc_addr] = 1'b1;
            end
        end
    end

    // Committed-write counter, saturating rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_hit && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Scoreboard and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          fwd;

        assign ra  = bus.rd_addr[k*AW +: AW];
        // wr_hit already excludes register 0, so a forward never targets it.
        assign fwd = (BYPASS != 0) && wr_hit && (bus.wr_addr == ra);

        assign bus.rd_data[k*XLEN +: XLEN] = fwd ? bus.wr_data : mem_q[ra];
        // A forwarded write retires the pending producer unless a new one allocs this cycle.
        assign bus.rd_busy[k] = busy_q[ra] &&
                                !(fwd && !(bus.alloc_en && (bus.alloc_addr == ra)));
    end

    assign bus.busy_vec = busy_q;
    assign bus.wr_count = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one bypassing instance and one non-bypassing
// instance share the same stimulus; expected values are hand-computed constants.
module tb_regfile_scoreboard;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();
    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_nb ();

    assign bus_nb.rd_addr    = bus.rd_addr;
    assign bus_nb.wr_en      = bus.wr_en;
    assign bus_nb.wr_addr    = bus.wr_addr;
    assign bus_nb.wr_data    = bus.wr_data;
    assign bus_nb.alloc_en   = bus.alloc_en;
    assign bus_nb.alloc_addr = bus.alloc_addr;
    assign bus_nb.flush      = bus.flush;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.rd_addr    = '0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.alloc_en   = 1'b0;
        bus.alloc_addr = '0;
        bus.flush      = 1'b0;
        #12 rst_n = 1'b1;
        step();

        // Reset state
        set_rd(5'd5, 5'd31);
        #1;
        chk("reset_rd0", bus.rd_data[63:0], 64'd0);
        chk("reset_rd1", bus.rd_data[127:64], 64'd0);
        chk("reset_busy_vec", 64'(bus.busy_vec), 64'd0);
        chk("reset_wr_count", 64'(bus.wr_count), 64'd0);

        // Write to register 0 is discarded and not forwarded
        set_rd(5'd0, 5'd31);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 64'hDEAD;
        #1;
        chk("zero_bypass", bus.rd_data[63:0], 64'd0);
        step();
        bus.wr_en = 1'b0;
        #1;
        chk("zero_stored", bus.rd_data[63:0], 64'd0);
        chk("zero_no_count", 64'(bus.wr_count), 64'd0);

        // Write 3 = 7 with same-cycle read
        set_rd(5'd3, 5'd31);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 64'd7;
        #1;
        chk("bypass_same_cycle", bus.rd_data[63:0], 64'd7);
        chk("nobypass_same_cycle", bus_nb.rd_data[63:0], 64'd0);
        step();
        bus.wr_en = 1'b0;
        #1;
        chk("bypass_next_cycle", bus.rd_data[63:0], 64'd7);
        chk("nobypass_next_cycle", bus_nb.rd_data[63:0], 64'd7);
        chk("count_one", 64'(bus.wr_count), 64'd1);

        // Alloc 4, then write 4 = 9 clears busy
        set_rd(5'd3, 5'd4);
        bus.alloc_en = 1'b1; bus.alloc_addr = 5'd4;
        step();
        bus.alloc_en = 1'b0;
        #1;
        chk("alloc4_busy_vec", 64'(bus.busy_vec), 64'h10);
        chk("alloc4_rd_busy", 64'(bus.rd_busy), 64'b10);
        chk("alloc4_nb_rd_busy", 64'(bus_nb.rd_busy), 64'b10);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 64'd9;
        #1;
        chk("wr4_rd_busy_bypass", 64'(bus.rd_busy), 64'b00);
        chk("wr4_rd_data_bypass", bus.rd_data[127:64], 64'd9);
        chk("wr4_nb_rd_busy", 64'(bus_nb.rd_busy), 64'b10);
        chk("wr4_nb_rd_data", bus_nb.rd_data[127:64], 64'd0);
        step();
        bus.wr_en = 1'b0;
        #1;
        chk("wr4_busy_cleared", 64'(bus.busy_vec), 64'h0);
        chk("wr4_stored", bus.rd_data[127:64], 64'd9);

        // Same-cycle alloc and write to 6: data lands, busy set
        set_rd(5'd6, 5'd4);
        bus.alloc_en = 1'b1; bus.alloc_addr = 5'd6;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd6; bus.wr_data = 64'd11;
        #1;
        chk("alloc_wr6_rd_data", bus.rd_data[63:0], 64'd11);
        step();
        bus.alloc_en = 1'b0; bus.wr_en = 1'b0;
        #1;
        chk("alloc_wr6_stored", bus.rd_data[63:0], 64'd11);
        chk("alloc_wr6_busy_vec", 64'(bus.busy_vec), 64'h40);
        chk("alloc_wr6_rd_busy", 64'(bus.rd_busy), 64'b01);

        // Alloc 1, 2, 3, then flush with a dropped alloc of 7
        for (int a = 1; a <= 3; a++) begin
            bus.alloc_en = 1'b1; bus.alloc_addr = 5'(a);
            step();
        end
        bus.alloc_en = 1'b0;
        #1;
        chk("allocs_busy_vec", 64'(bus.busy_vec), 64'h4E);
        bus.flush = 1'b1; bus.alloc_en = 1'b1; bus.alloc_addr = 5'd7;
        step();
        bus.flush = 1'b0; bus.alloc_en = 1'b0;
        set_rd(5'd3, 5'd6);
        #1;
        chk("flush_busy_vec", 64'(bus.busy_vec), 64'h0);
        chk("flush_mem3", bus.rd_data[63:0], 64'd7);
        chk("flush_mem6", bus.rd_data[127:64], 64'd11);
        chk("flush_count", 64'(bus.wr_count), 64'd3);

        // Write 9 = 0x55, then asynchronous reset mid-cycle
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 64'h55;
        step();
        bus.wr_en = 1'b0;
        set_rd(5'd9, 5'd3);
        #1;
        chk("wr9_stored", bus.rd_data[63:0], 64'h55);
        chk("wr9_count", 64'(bus.wr_count), 64'd4);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rd9", bus.rd_data[63:0], 64'd0);
        chk("async_rst_rd3", bus.rd_data[127:64], 64'd0);
        chk("async_rst_count", 64'(bus.wr_count), 64'd0);
        // A write presented while reset is held must not land
        bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 64'h77;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        #2 rst_n = 1'b1;
        set_rd(5'd10, 5'd9);
        #1;
        chk("rst_abort_wr10", bus.rd_data[63:0], 64'd0);
        chk("rst_abort_count", 64'(bus.wr_count), 64'd0);

        // Saturation of wr_count
        bus.wr_en = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = 64'h1234;
        repeat (65534) step();
        chk("count_fffe", 64'(bus.wr_count), 64'hFFFE);
        step();
        chk("count_ffff", 64'(bus.wr_count), 64'hFFFF);
        repeat (64) step();
        chk("count_saturated", 64'(bus.wr_count), 64'hFFFF);
        bus.wr_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the sequential core's fixed 32x64 read-only register file.
- Adds a clocked write port, write-to-read bypass, hardwired zero register, configurable width/depth/read-port count, and a per-register busy scoreboard for the pipelined core's hazard detection.
- Sits between decode (read/alloc), writeback (write) and the pipeline flush logic.

Parameters:
XLEN, 64, data width in bits
NREGS, 32, number of architectural registers (power of two, >= 2)
AW, $clog2(NREGS), register address width (derived, not overridden)
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NRD*AW  packed read addresses; port k at [k*AW +: AW]
rd_data  out  NRD*XLEN  packed read data, combinational
rd_busy  out  NRD  per read port: addressed register has a pending write
wr_en  in  1  writeback write strobe
wr_addr  in  AW  writeback destination
wr_data  in  XLEN  writeback data
alloc_en  in  1  decode marks a destination as pending
alloc_addr  in  AW  register to mark busy
flush  in  1  clear all busy bits (pipeline flush)
busy_vec  out  NREGS  full scoreboard, bit i = register i pending
wr_count  out  16  number of committed writes since reset, saturating

Behaviour:
- Reset (rst_n low, async): all NREGS registers = 0; busy_vec = 0; wr_count = 0. rd_data reflects zeros immediately. Reset asserted mid-cycle aborts any write in that cycle.
- Register 0 reads 0 always; writes to addr 0 are discarded, are not counted in wr_count, and never set/clear busy; alloc to 0 ignored.
- Write: on posedge clk with wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data; stored value visible next cycle.
- Read: rd_data[k] = mem[rd_addr[k]] combinationally. If BYPASS=1 and wr_en=1 and wr_addr==rd_addr[k]!=0, rd_data[k] = wr_data in the same cycle. Multiple ports reading the same address all return the same value.
- Scoreboard, evaluated per register r at posedge clk, priority highest first:
  - flush=1: busy[r] <= 0 for all r (a simultaneous alloc is dropped).
  - alloc_en=1 and alloc_addr==r: busy[r] <= 1 (alloc wins over same-cycle write to the same r; the new producer is outstanding).
  - wr_en=1 and wr_addr==r: busy[r] <= 0.
  - otherwise: hold.
- rd_busy[k] = busy[rd_addr[k]], except it reads 0 when BYPASS=1 and the same-cycle write to that address clears it (write hits without a same-cycle alloc). rd_busy for addr 0 is always 0.
- Write to a non-busy register is legal and updates data; busy stays 0.
- wr_count increments by 1 on each accepted write (wr_en=1, addr!=0); saturates at 16'hFFFF, no wrap.
- flush does not alter register contents or wr_count.
- No X propagation: out-of-range addresses are impossible since NREGS = 2^AW.

Test Plan:
- Reset then read ports 0/1 at addr 5/31 -> rd_data = 0/0, busy_vec = 0, wr_count = 0; write addr 0 data 64'hDEAD -> read addr 0 = 0, wr_count = 0.
- Write addr 3 = 64'd7 while port 0 reads addr 3 (BYPASS=1) -> rd_data0 = 7 in the same cycle; next cycle with wr_en=0 -> still 7; wr_count = 1. With BYPASS=0 -> same-cycle read = 0, next cycle = 7.
- alloc addr 4 -> next cycle busy_vec[4] = 1, rd_busy = 1 for port reading 4; write addr 4 = 9 -> same cycle rd_busy = 0 (bypass) and rd_data = 9; next cycle busy_vec[4] = 0.
- Same cycle alloc addr 6 and write addr 6 = 11 -> next cycle mem[6] = 11, busy_vec[6] = 1.
- alloc addrs 1, 2, 3 over three cycles, then flush together with alloc addr 7 -> busy_vec = 0 next cycle; mem unchanged.
- Drop rst_n asynchronously mid-cycle after writing addr 9 = 64'h55 -> rd_data for addr 9 = 0 without waiting for a clock edge; 70000 writes -> wr_count = 16'hFFFF.
